// File: rtl/uart_tx_pmod.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pmod
// Purpose  : 8N1 UART transmitter; one byte per valid/ready handshake onto an
//            idle-high PMOD line (start, 8 data bits LSB first, stop bit(s)).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_pmod #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK100MHZ,
  input  logic       ck_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx_of_pmod,
  output logic       busy
);

  localparam int              c_cw        = $clog2(CLKS_PER_BIT);
  localparam logic [c_cw-1:0] c_last      = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      c_last_stop = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_cw-1:0] r_baud,  w_baud_nxt;
  logic [2:0]      r_bit,   w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            w_line_nxt;
  logic            w_accept;
  logic            w_bit_end;

  // tx_ready is a registered copy of (state == IDLE), so it is safe to use here
  assign w_accept  = tx_valid & tx_ready;
  assign w_bit_end = (r_baud == c_last);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_shift_nxt = tx_data;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end else begin
          w_baud_nxt = r_baud + c_cw'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud + c_cw'(1);
        end
      end
      S_STOP: begin
        // bit index is reused to count stop bits
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == c_last_stop) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + c_cw'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // line value is derived from the next state so the output is a plain flop
    case (w_state_nxt)
      S_START: w_line_nxt = 1'b0;
      S_DATA:  w_line_nxt = w_shift_nxt[0];
      default: w_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      r_state         <= S_IDLE;
      r_baud          <= '0;
      r_bit           <= '0;
      r_shift         <= '0;
      uart_tx_of_pmod <= 1'b1;
      tx_ready        <= 1'b1;
      busy            <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_baud          <= w_baud_nxt;
      r_bit           <= w_bit_nxt;
      r_shift         <= w_shift_nxt;
      uart_tx_of_pmod <= w_line_nxt;
      tx_ready        <= (w_state_nxt == S_IDLE);
      busy            <= (w_state_nxt != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_pmod.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_pmod
// Purpose  : Randomised self-checking bench for uart_tx_pmod against a
//            frame-level model of the expected line waveform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_pmod;

  localparam int CPB   = 6;
  localparam int SB    = 1;
  localparam int FRAME = (9 + SB) * CPB;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       line;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_pmod #(
    .CLK_FREQ    (CPB * 1000),
    .BAUD        (1000),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .CLK100MHZ      (clk),
    .ck_rst         (rst_n),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .uart_tx_of_pmod(line),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got=%b expected=%b", tag, $time, got, exp);
  endtask

  // Expected line level k cycles into a frame carrying byte b
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int idx;
    idx = k / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_line", line, 1'b1);
      chk("idle_ready", tx_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end
  endtask

  // Presents b with tx_valid; the accepting edge is the next posedge
  task automatic start_send(input logic [7:0] b);
    int w;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    w = 0;
    while (!tx_ready && w < 2 * FRAME) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", tx_ready, 1'b1);
  endtask

  task automatic check_frame(input logic [7:0] b, input bit hold, input bit pulse,
                             input logic [7:0] data_after);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk("frame_line", line, exp_line(b, k));
      chk("frame_busy", busy, 1'b1);
      chk("frame_ready", tx_ready, 1'b0);
      if (k == 0 && !hold) tx_valid = 1'b0;
      if (k == 2) tx_data = data_after;
      if (pulse && k == 3 * CPB) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      if (pulse && k == 3 * CPB + 1) tx_valid = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] b;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    repeat (3) begin
      @(negedge clk);
      chk("rst_line", line, 1'b1);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    rst_n = 1'b1;
    idle_check(200);

    // Single '5'
    start_send(8'h35);
    check_frame(8'h35, 1'b0, 1'b0, 8'($urandom));
    idle_check(2);

    // Back-to-back with valid held: exactly one idle cycle between frames
    start_send(8'h35);
    check_frame(8'h35, 1'b1, 1'b0, 8'hA5);
    idle_check(1);
    check_frame(8'hA5, 1'b0, 1'b0, 8'h00);
    idle_check(3);

    // Handshake during DATA is ignored and does not queue a frame
    start_send(8'h00);
    check_frame(8'h00, 1'b0, 1'b1, 8'h00);
    idle_check(2 * FRAME);

    // Reset in the middle of DATA aborts the frame immediately
    b = 8'($urandom);
    start_send(b);
    for (int k = 0; k < 4 * CPB + 2; k++) begin
      @(negedge clk);
      chk("abort_line", line, exp_line(b, k));
      if (k == 0) tx_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_rst_line", line, 1'b1);
    chk("abort_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(2 * CPB);
    b = 8'($urandom);
    start_send(b);
    check_frame(b, 1'b0, 1'b0, 8'($urandom));
    idle_check(1);

    // Random bytes with random idle gaps
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      start_send(b);
      check_frame(b, 1'b0, 1'b0, 8'($urandom));
      idle_check(1 + $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
